// File: rtl/prescaled_updown_counter_pkg.sv
// Shared types and helpers for the prescaled up/down counter.
// Optional compare channel is enabled with the macro COUNTER_COMPARE_EN.
package counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_e;

  typedef enum logic {
    OVF_WRAP = 1'b0,
    OVF_SAT  = 1'b1
  } ovf_mode_e;

  // Width needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/prescaled_updown_counter_if.sv
// Control/status bundle of one count channel.
// The compare channel (cmp_value/cmp_match) exists only when COUNTER_COMPARE_EN is defined.
interface prescaled_updown_counter_if #(
  parameter int WIDTH = 8
);

  logic             clear;
  logic             enable;
  logic             up_down;
  logic             saturate;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic             tick;
  logic             terminal;
  logic             at_limit;
`ifdef COUNTER_COMPARE_EN
  logic [WIDTH-1:0] cmp_value;
  logic             cmp_match;
`else
  // Compare channel not built.
`endif

  // Side that drives the controls (board logic).
  modport master (
    output clear, enable, up_down, saturate, load, load_value,
    input  Q, tick, terminal, at_limit
`ifdef COUNTER_COMPARE_EN
    , output cmp_value
    , input  cmp_match
`endif
  );

  // The counter itself.
  modport slave (
    input  clear, enable, up_down, saturate, load, load_value,
    output Q, tick, terminal, at_limit
`ifdef COUNTER_COMPARE_EN
    , input  cmp_value
    , output cmp_match
`endif
  );

endinterface

// File: rtl/prescaled_updown_counter_tick_prescaler.sv
// Divides enabled clock cycles down to one count step every CYCLES_PER_TICK cycles.
// step is combinational: high while enabled on the last prescaler value.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int CYCLES_PER_TICK = 12000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam int DIV_W = clog2_min1(CYCLES_PER_TICK);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CYCLES_PER_TICK - 1);

  logic [DIV_W-1:0] count;

  assign step = enable && (count == LAST);

  // Divider: restarts on clear, advances only while enabled, rolls over after LAST.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/prescaled_updown_counter.sv
// Parametrised up/down counter with prescaler, synchronous clear/load,
// wrap or saturate overflow, registered tick/terminal pulses.
// Define COUNTER_COMPARE_EN to add the cmp_value/cmp_match compare channel.
module prescaled_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int CYCLES_PER_TICK = 12000000
) (
  input logic                        clock,
  input logic                        reset_n,
  prescaled_updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VALUE = '1;

  logic             step;
  logic [WIDTH-1:0] q_r;
  logic             tick_r;
  logic             terminal_r;
  logic [WIDTH-1:0] stepped;
  logic             hit_limit;
  count_dir_e       dir;
  ovf_mode_e        mode;

  // Load also restarts the period, so the divider clears on either strobe.
  tick_prescaler #(
    .CYCLES_PER_TICK (CYCLES_PER_TICK)
  ) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (bus.clear | bus.load),
    .enable  (bus.enable),
    .step    (step)
  );

  // Value the counter would take if a step were applied now.
  always_comb begin
    // NOTE: every output of this block is assigned up front so no path can infer a latch.
    dir       = count_dir_e'(bus.up_down);
    mode      = ovf_mode_e'(bus.saturate);
    hit_limit = (dir == DIR_UP) ? (q_r == MAX_VALUE) : (q_r == '0);
    stepped   = q_r;
    if (!hit_limit) begin
      stepped = (dir == DIR_UP) ? q_r + 1'b1 : q_r - 1'b1;
    end else if (mode == OVF_WRAP) begin
      stepped = (dir == DIR_UP) ? '0 : MAX_VALUE;
    end
  end

  // Count register and step pulses; priority clear > load > step > hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_r        <= '0;
      tick_r     <= 1'b0;
      terminal_r <= 1'b0;
    end else if (bus.clear) begin
      q_r        <= '0;
      tick_r     <= 1'b0;
      terminal_r <= 1'b0;
    end else if (bus.load) begin
      q_r        <= bus.load_value;
      tick_r     <= 1'b0;
      terminal_r <= 1'b0;
    end else if (step) begin
      q_r        <= stepped;
      tick_r     <= 1'b1;
      terminal_r <= hit_limit;
    end else begin
      tick_r     <= 1'b0;
      terminal_r <= 1'b0;
    end
  end

  assign bus.Q        = q_r;
  assign bus.tick     = tick_r;
  assign bus.terminal = terminal_r;
  // Level: the current count sits at the limit for the present direction.
  assign bus.at_limit = hit_limit;

`ifdef COUNTER_COMPARE_EN
  logic cmp_match_r;

  // Compare pulse: only a real step landing on cmp_value raises it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cmp_match_r <= 1'b0;
    end else if (!bus.clear && !bus.load && step) begin
      cmp_match_r <= (stepped == bus.cmp_value);
    end else begin
      cmp_match_r <= 1'b0;
    end
  end

  assign bus.cmp_match = cmp_match_r;
`else
  // No compare channel in this build.
`endif

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench for prescaled_updown_counter, WIDTH=4, CYCLES_PER_TICK=4.
// Expectations are queued as stimulus is applied and checked as cycles elapse.
module tb_prescaled_updown_counter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prescaled_updown_counter_if #(.WIDTH(4)) bus ();

  prescaled_updown_counter #(
    .WIDTH           (4),
    .CYCLES_PER_TICK (4)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string      tag;
    int         wait_cycles;
    logic [3:0] q;
    logic       tick;
    logic       terminal;
    logic       at_limit;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic push(input string tag, input int wait_cycles, input logic [3:0] q,
                      input logic tick, input logic terminal, input logic at_limit);
    exp_t e;
    e.tag         = tag;
    e.wait_cycles = wait_cycles;
    e.q           = q;
    e.tick        = tick;
    e.terminal    = terminal;
    e.at_limit    = at_limit;
    sb.push_back(e);
  endtask

  // Pop each queued expectation once its cycles have elapsed and compare.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      repeat (e.wait_cycles) @(posedge clk);
      #1;
      check({e.tag, ".Q"},        bus.Q,        e.q);
      check({e.tag, ".tick"},     bus.tick,     {3'b0, e.tick});
      check({e.tag, ".terminal"}, bus.terminal, {3'b0, e.terminal});
      check({e.tag, ".at_limit"}, bus.at_limit, {3'b0, e.at_limit});
    end
  endtask

  int   tick_count;
  int   term_count;
  logic last_term;

  initial begin
    rst_n          = 1'b0;
    bus.clear      = 1'b0;
    bus.enable     = 1'b0;
    bus.up_down    = 1'b1;
    bus.saturate   = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = 4'd0;
`ifdef COUNTER_COMPARE_EN
    bus.cmp_value  = 4'd3;
`endif

    // Reset values, at_limit in both directions.
    #2;
    check("rst.Q", bus.Q, 4'd0);
    check("rst.tick", bus.tick, 4'd0);
    check("rst.terminal", bus.terminal, 4'd0);
    check("rst.at_limit_up", bus.at_limit, 4'd0);
    bus.up_down = 1'b0;
    #1;
    check("rst.at_limit_down", bus.at_limit, 4'd1);
    bus.up_down = 1'b1;
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // A: up, wrap, enable held.
    bus.enable = 1'b1;
    push("a_first_step", 4, 4'd1, 1'b1, 1'b0, 1'b0);
    push("a_after_step", 1, 4'd1, 1'b0, 1'b0, 1'b0);
    drain();
    tick_count = 0;
    term_count = 0;
    last_term  = 1'b0;
    for (int i = 0; i < 59; i++) begin
      @(posedge clk); #1;
      if (bus.tick) tick_count++;
      if (bus.terminal) term_count++;
      last_term = bus.terminal;
    end
    check("a_64.Q", bus.Q, 4'd0);
    check("a_64.terminal_on_wrap", {3'b0, last_term}, 4'd1);
    check("a_64.terminal_count", 4'(term_count), 4'd1);
    check("a_64.tick_count", 4'(tick_count), 4'd15);

    // B: saturate up from 14.
    bus.load = 1'b1; bus.load_value = 4'd14; bus.saturate = 1'b1;
    push("b_load", 1, 4'd14, 1'b0, 1'b0, 1'b0);
    drain();
    bus.load = 1'b0;
    push("b_to15", 4, 4'd15, 1'b1, 1'b0, 1'b1);
    push("b_sat",  4, 4'd15, 1'b1, 1'b1, 1'b1);
    drain();

    // C: down from 0, wrap then saturate.
    bus.up_down = 1'b0; bus.saturate = 1'b0; bus.load = 1'b1; bus.load_value = 4'd0;
    push("c_load0", 1, 4'd0, 1'b0, 1'b0, 1'b1);
    drain();
    bus.load = 1'b0;
    push("c_wrap", 4, 4'd15, 1'b1, 1'b1, 1'b0);
    drain();
    bus.saturate = 1'b1; bus.load = 1'b1;
    push("c_load0_sat", 1, 4'd0, 1'b0, 1'b0, 1'b1);
    drain();
    bus.load = 1'b0;
    push("c_sat", 4, 4'd0, 1'b1, 1'b1, 1'b1);
    drain();

    // D: load on the exact cycle a step is due.
    bus.up_down = 1'b1; bus.saturate = 1'b0; bus.load = 1'b1; bus.load_value = 4'd0;
    push("d_load0", 1, 4'd0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.load = 1'b0;
    push("d_pre", 3, 4'd0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.load = 1'b1; bus.load_value = 4'd9;
    push("d_load_on_step", 1, 4'd9, 1'b0, 1'b0, 1'b0);
    drain();
    bus.load = 1'b0;
    push("d_wait", 3, 4'd9, 1'b0, 1'b0, 1'b0);
    push("d_step", 1, 4'd10, 1'b1, 1'b0, 1'b0);
    drain();

    // E: clear beats load; enable gap delays the step by its length.
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_value = 4'd5;
    push("e_clear_load", 1, 4'd0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.clear = 1'b0; bus.load = 1'b0;
    push("e_pre", 2, 4'd0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.enable = 1'b0;
    push("e_gated", 3, 4'd0, 1'b0, 1'b0, 1'b0);
    drain();
    bus.enable = 1'b1;
    push("e_not_yet", 1, 4'd0, 1'b0, 1'b0, 1'b0);
    push("e_step",    1, 4'd1, 1'b1, 1'b0, 1'b0);
    drain();

    // F: async reset mid-period with Q=7.
    bus.load = 1'b1; bus.load_value = 4'd7;
    push("f_load", 1, 4'd7, 1'b0, 1'b0, 1'b0);
    drain();
    bus.load = 1'b0;
    push("f_mid", 2, 4'd7, 1'b0, 1'b0, 1'b0);
    drain();
    #2 rst_n = 1'b0;
    #1;
    check("f_async.Q", bus.Q, 4'd0);
    check("f_async.tick", bus.tick, 4'd0);
    #1 rst_n = 1'b1;
    push("f_post",      3, 4'd0, 1'b0, 1'b0, 1'b0);
    push("f_post_step", 1, 4'd1, 1'b1, 1'b0, 1'b0);
    drain();

`ifdef COUNTER_COMPARE_EN
    // G: compare pulse only on the step landing on 3, never on load.
    bus.load = 1'b1; bus.load_value = 4'd3;
    @(posedge clk); #1;
    check("g_load_no_match", {3'b0, bus.cmp_match}, 4'd0);
    bus.load_value = 4'd0;
    @(posedge clk); #1;
    bus.load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("g_step%0d_cmp", k), {3'b0, bus.cmp_match}, (k == 3) ? 4'd1 : 4'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
